// File: rtl/pixel_stream_source_if.sv
// Pixel stream bundle: control requests into the source and the valid-qualified raster stream out.
// The stream carries no backpressure: a pixel is transferred in every cycle where dataout_valid is high, and the consumer must accept it.
interface pixel_stream_source_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  start;
   logic                  stop;
   logic                  loop;
   logic [1:0]            pattern;
   logic [DATA_WIDTH-1:0] const_value;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  dataout_valid;
   logic                  line_start;
   logic                  line_end;
   logic                  frame_end;
   logic                  busy;

   modport master (
      input  start, stop, loop, pattern, const_value,
      output data_out, dataout_valid, line_start, line_end, frame_end, busy
   );

   modport slave (
      output start, stop, loop, pattern, const_value,
      input  data_out, dataout_valid, line_start, line_end, frame_end, busy
   );
endinterface

// File: rtl/pixel_stream_source.sv
// Raster test-pattern source emitting IMAGE_WIDTH x IMAGE_HEIGHT frames with optional line blanking.
// Define PIXEL_SRC_LFSR_EN to build the LFSR pattern; without it pattern 2 outputs const_value.
module pixel_stream_source #(
   parameter int DATA_WIDTH   = 8,
   parameter int IMAGE_WIDTH  = 128,
   parameter int IMAGE_HEIGHT = 6,
   parameter int HBLANK       = 0,
   parameter int CNT_WIDTH    = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   pixel_stream_source_if.master bus,
   output logic [1:0]           state_dbg
);
   typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, BLANK = 2'd2} state_t;

   localparam logic [CNT_WIDTH-1:0] LAST_COL   = CNT_WIDTH'(IMAGE_WIDTH - 1);
   localparam logic [CNT_WIDTH-1:0] LAST_ROW   = CNT_WIDTH'(IMAGE_HEIGHT - 1);
   localparam logic [CNT_WIDTH-1:0] BLANK_LAST = CNT_WIDTH'((HBLANK > 0) ? HBLANK - 1 : 0);
   localparam logic [15:0]          LFSR_SEED  = 16'hACE1;

   state_t                state, state_nxt;
   logic [CNT_WIDTH-1:0]  col, col_nxt, row, row_nxt, blank_cnt, blank_nxt;
   logic [CNT_WIDTH-1:0]  col_p1, row_p1;
   logic [1:0]            pat, pat_nxt;
   logic [DATA_WIDTH-1:0] cval, cval_nxt, pixel;
   logic                  stop_pend, stop_pend_nxt, frame_done, frame_done_nxt;
   logic [DATA_WIDTH-1:0] data_nxt;
   logic                  valid_nxt, ls_nxt, le_nxt, fe_nxt;
   logic                  last_col, last_row, stop_req;
`ifdef PIXEL_SRC_LFSR_EN
   logic [15:0]           lfsr, lfsr_nxt;
`endif

   assign state_dbg = state;
   assign col_p1    = col + CNT_WIDTH'(1);
   assign row_p1    = row + CNT_WIDTH'(1);
   assign last_col  = (col == LAST_COL);
   assign last_row  = (row == LAST_ROW);
   assign stop_req  = stop_pend | bus.stop;

   always_comb begin
      case (pat)
         2'd0:    pixel = col_p1[DATA_WIDTH-1:0];
         2'd1:    pixel = row_p1[DATA_WIDTH-1:0];
`ifdef PIXEL_SRC_LFSR_EN
         2'd2:    pixel = lfsr[DATA_WIDTH-1:0];
`endif
         default: pixel = cval;
      endcase
   end

   always_comb begin
      state_nxt      = state;
      col_nxt        = col;
      row_nxt        = row;
      blank_nxt      = blank_cnt;
      pat_nxt        = pat;
      cval_nxt       = cval;
      stop_pend_nxt  = stop_pend;
      frame_done_nxt = frame_done;
      valid_nxt      = 1'b0;
      data_nxt       = '0;
      ls_nxt         = 1'b0;
      le_nxt         = 1'b0;
      fe_nxt         = 1'b0;
`ifdef PIXEL_SRC_LFSR_EN
      lfsr_nxt       = lfsr;
`endif
      case (state)
         IDLE: begin
            if (bus.start) begin
               state_nxt      = ACTIVE;
               col_nxt        = '0;
               row_nxt        = '0;
               blank_nxt      = '0;
               pat_nxt        = bus.pattern;
               cval_nxt       = bus.const_value;
               stop_pend_nxt  = bus.stop;
               frame_done_nxt = 1'b0;
`ifdef PIXEL_SRC_LFSR_EN
               lfsr_nxt       = LFSR_SEED;
`endif
            end
         end
         ACTIVE: begin
            valid_nxt = 1'b1;
            data_nxt  = pixel;
            ls_nxt    = (col == '0);
            le_nxt    = last_col;
            fe_nxt    = last_col & last_row;
`ifdef PIXEL_SRC_LFSR_EN
            lfsr_nxt  = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
`endif
            if (bus.stop) stop_pend_nxt = 1'b1;
            if (!last_col) begin
               col_nxt = col_p1;
            end else begin
               col_nxt = '0;
               row_nxt = last_row ? '0 : row_p1;
               // A pending stop ends at this line boundary and skips blanking.
               if (stop_req) begin
                  state_nxt     = IDLE;
                  stop_pend_nxt = 1'b0;
               end else if (last_row && !bus.loop) begin
                  state_nxt      = (HBLANK > 0) ? BLANK : IDLE;
                  frame_done_nxt = (HBLANK > 0);
               end else if (HBLANK > 0) begin
                  state_nxt = BLANK;
               end
            end
         end
         BLANK: begin
            if (bus.stop && !frame_done) stop_pend_nxt = 1'b1;
            if (blank_cnt == BLANK_LAST) begin
               blank_nxt      = '0;
               frame_done_nxt = 1'b0;
               if (frame_done) begin
                  state_nxt     = IDLE;
                  stop_pend_nxt = 1'b0;
               end else begin
                  state_nxt = ACTIVE;
               end
            end else begin
               blank_nxt = blank_cnt + CNT_WIDTH'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state             <= IDLE;
         col               <= '0;
         row               <= '0;
         blank_cnt         <= '0;
         pat               <= '0;
         cval              <= '0;
         stop_pend         <= 1'b0;
         frame_done        <= 1'b0;
         bus.data_out      <= '0;
         bus.dataout_valid <= 1'b0;
         bus.line_start    <= 1'b0;
         bus.line_end      <= 1'b0;
         bus.frame_end     <= 1'b0;
         bus.busy          <= 1'b0;
`ifdef PIXEL_SRC_LFSR_EN
         lfsr              <= LFSR_SEED;
`endif
      end else begin
         state             <= state_nxt;
         col               <= col_nxt;
         row               <= row_nxt;
         blank_cnt         <= blank_nxt;
         pat               <= pat_nxt;
         cval              <= cval_nxt;
         stop_pend         <= stop_pend_nxt;
         frame_done        <= frame_done_nxt;
         bus.data_out      <= data_nxt;
         bus.dataout_valid <= valid_nxt;
         bus.line_start    <= ls_nxt;
         bus.line_end      <= le_nxt;
         bus.frame_end     <= fe_nxt;
         bus.busy          <= (state != IDLE);
`ifdef PIXEL_SRC_LFSR_EN
         lfsr              <= lfsr_nxt;
`endif
      end
   end
endmodule

// File: tb/tb_pixel_stream_source.sv
// Bench for pixel_stream_source: two instances (HBLANK 0 and 4) driven identically and compared
// cycle by cycle against an expected-stream trace built from the raster rules.
module tb_pixel_stream_source;
  localparam int DW   = 8;
  localparam int W    = 128;
  localparam int H    = 6;
  localparam int HB_B = 4;
  localparam int TW   = DW + 5;
  localparam int MAXE = 2400;
`ifdef PIXEL_SRC_LFSR_EN
  localparam bit LFSR_ON = 1'b1;
`else
  localparam bit LFSR_ON = 1'b0;
`endif

  typedef struct {
    int pat; logic [DW-1:0] cval; bit loop;
    int stop_edge; int rst_edge; int restart_edge; bit pre_stop;
    int exp_pix_a; int exp_busy_b; int exp_first; int exp_second;
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pixel_stream_source_if #(.DATA_WIDTH(DW)) ifa ();
  pixel_stream_source_if #(.DATA_WIDTH(DW)) ifb ();
  logic [1:0] state_a, state_b;

  pixel_stream_source #(.DATA_WIDTH(DW), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .HBLANK(0), .CNT_WIDTH(16))
    dut_a (.clk(clk), .rst(rst), .bus(ifa), .state_dbg(state_a));
  pixel_stream_source #(.DATA_WIDTH(DW), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .HBLANK(HB_B), .CNT_WIDTH(16))
    dut_b (.clk(clk), .rst(rst), .bus(ifb), .state_dbg(state_b));

  // scoreboard
  logic [TW-1:0] exp_a[$];
  logic [TW-1:0] exp_b[$];
  logic [15:0]   lfsr_seq[4096];
  int checks = 0;
  int errors = 0;
  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [TW-1:0] pack_a();
    return {ifa.busy, ifa.frame_end, ifa.line_end, ifa.line_start, ifa.dataout_valid, ifa.data_out};
  endfunction

  function automatic logic [TW-1:0] pack_b();
    return {ifb.busy, ifb.frame_end, ifb.line_end, ifb.line_start, ifb.dataout_valid, ifb.data_out};
  endfunction

  // driver
  task automatic drive(input bit st, input bit sp, input logic [1:0] p, input logic [DW-1:0] cv, input bit lp);
    ifa.start = st; ifb.start = st;
    ifa.stop = sp; ifb.stop = sp;
    ifa.pattern = p; ifb.pattern = p;
    ifa.const_value = cv; ifb.const_value = cv;
    ifa.loop = lp; ifb.loop = lp;
  endtask

  // Expected outputs after each edge, edge 0 being the start edge. Lines are laid out in raster
  // order followed by hb idle cycles; a stop truncates after the first line ending at/after it.
  task automatic build_trace(input int hb, input vec_t v, input bit to_b);
    logic [TW-1:0] q[$];
    logic [DW-1:0] pv;
    int n, r, line_last;
    bit done;
    q.push_back('0);
    n = 0; r = 0; done = 1'b0;
    while (!done) begin
      for (int c = 0; c < W; c++) begin
        case (v.pat)
          0: pv = DW'(c + 1);
          1: pv = DW'(r + 1);
          2: pv = LFSR_ON ? lfsr_seq[n][DW-1:0] : v.cval;
          default: pv = v.cval;
        endcase
        q.push_back({1'b1, 1'(r == H-1 && c == W-1), 1'(c == W-1), 1'(c == 0), 1'b1, pv});
        n++;
      end
      line_last = q.size() - 1;
      if (v.stop_edge >= 0 && v.stop_edge <= line_last) begin
        done = 1'b1;
      end else begin
        for (int g = 0; g < hb; g++) q.push_back({1'b1, {(TW-1){1'b0}}});
        if (r == H-1 && !v.loop) done = 1'b1;
        if (q.size() > MAXE) done = 1'b1;
      end
      r = (r == H-1) ? 0 : r + 1;
    end
    if (to_b) exp_b = q;
    else exp_a = q;
  endtask

  task automatic run(input int idx, input vec_t v);
    int len, pix_a, busy_b, nf;
    logic [DW-1:0] firsts[2];
    logic [TW-1:0] ea, eb;
    bit rst_done;
    build_trace(0, v, 1'b0);
    build_trace(HB_B, v, 1'b1);
    len = ((exp_a.size() > exp_b.size()) ? exp_a.size() : exp_b.size()) + 2;
    if (v.rst_edge >= 0 && v.rst_edge + 2 < len) len = v.rst_edge + 2;
    if (len > MAXE) len = MAXE;
    if (v.pre_stop) begin
      @(negedge clk);
      drive(1'b0, 1'b1, 2'd0, '0, 1'b0);
    end
    @(negedge clk);
    drive(1'b1, v.stop_edge == 0, 2'(v.pat), v.cval, v.loop);
    pix_a = 0; busy_b = 0; nf = 0;
    firsts[0] = '0; firsts[1] = '0;
    for (int k = 0; k < len; k++) begin
      @(posedge clk);
      #1;
      rst_done = (v.rst_edge >= 0 && k >= v.rst_edge);
      ea = (rst_done || k >= exp_a.size()) ? '0 : exp_a[k];
      eb = (rst_done || k >= exp_b.size()) ? '0 : exp_b[k];
      check($sformatf("v%0d_a@%0d", idx, k), 32'(pack_a()), 32'(ea));
      check($sformatf("v%0d_b@%0d", idx, k), 32'(pack_b()), 32'(eb));
      if (ifa.dataout_valid) begin
        if (nf < 2) firsts[nf] = ifa.data_out;
        nf++;
        pix_a++;
      end
      if (ifb.busy) busy_b++;
      // pattern and const_value wander after start; the DUT must keep its latched copies
      drive(k + 1 == v.restart_edge, k + 1 == v.stop_edge, 2'($urandom_range(0, 3)), DW'($urandom), v.loop);
      rst = (k + 1 == v.rst_edge);
    end
    drive(1'b0, 1'b0, 2'd0, '0, 1'b0);
    rst = 1'b0;
    if (v.exp_pix_a >= 0) check($sformatf("v%0d_pixels_a", idx), pix_a, v.exp_pix_a);
    if (v.exp_busy_b >= 0) check($sformatf("v%0d_busy_b", idx), busy_b, v.exp_busy_b);
    if (v.exp_first >= 0) check($sformatf("v%0d_first", idx), 32'(firsts[0]), v.exp_first);
    if (v.exp_second >= 0) check($sformatf("v%0d_second", idx), 32'(firsts[1]), v.exp_second);
  endtask

  function automatic vec_t mk(input int pat, input int cval, input bit loop, input int stop_edge,
                              input int rst_edge, input int restart_edge, input bit pre_stop,
                              input int exp_pix_a, input int exp_busy_b, input int exp_first,
                              input int exp_second);
    vec_t v;
    v.pat = pat; v.cval = DW'(cval); v.loop = loop; v.stop_edge = stop_edge;
    v.rst_edge = rst_edge; v.restart_edge = restart_edge; v.pre_stop = pre_stop;
    v.exp_pix_a = exp_pix_a; v.exp_busy_b = exp_busy_b;
    v.exp_first = exp_first; v.exp_second = exp_second;
    return v;
  endfunction

  initial begin
    logic [15:0] x;
    vec_t rv;
    x = 16'hACE1;
    for (int i = 0; i < 4096; i++) begin
      lfsr_seq[i] = x;
      x = {x[0] ^ x[2] ^ x[3] ^ x[5], x[15:1]};
    end

    //         pat cval  loop stop rst  restart pre  pix_a busy_b first                    second
    vecs[0]  = mk(0, 8'h00, 0, -1,  -1,  -1,   0,   768,  792,   1,                       2);
    vecs[1]  = mk(1, 8'h00, 0, -1,  -1,  -1,   0,   768,  792,   1,                       1);
    vecs[2]  = mk(2, 8'h3C, 0, -1,  -1,  -1,   0,   768,  792,   LFSR_ON ? 8'hE1 : 8'h3C, LFSR_ON ? 8'h70 : 8'h3C);
    vecs[3]  = mk(0, 8'h00, 1, 200, -1,  -1,   0,   256,  -1,    1,                       2);
    vecs[4]  = mk(0, 8'h00, 0, -1,  51,  -1,   0,   50,   -1,    1,                       2);
    vecs[5]  = mk(0, 8'h00, 0, -1,  -1,  -1,   0,   768,  792,   1,                       2);
    vecs[6]  = mk(1, 8'h00, 0, -1,  -1,  300,  0,   768,  792,   1,                       1);
    vecs[7]  = mk(3, 8'hA5, 0, 0,   -1,  -1,   0,   128,  128,   8'hA5,                   8'hA5);
    vecs[8]  = mk(3, 8'h5A, 0, -1,  -1,  -1,   1,   768,  792,   8'h5A,                   8'h5A);
    vecs[9]  = mk(1, 8'h00, 1, -1,  1700, -1,  0,   1699, -1,    1,                       1);
    vecs[10] = mk(2, 8'h11, 1, 900, -1,  -1,   0,   1024, -1,    LFSR_ON ? 8'hE1 : 8'h11, LFSR_ON ? 8'h70 : 8'h11);

    rst = 1'b1;
    drive(1'b0, 1'b0, 2'd0, '0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_a", 32'(pack_a()), 32'd0);
    check("reset_b", 32'(pack_b()), 32'd0);
    check("reset_state_a", 32'(state_a), 32'd0);
    check("reset_state_b", 32'(state_b), 32'd0);
    rst = 1'b0;

    // stop while idle must be dropped
    @(negedge clk);
    drive(1'b0, 1'b1, 2'd0, '0, 1'b0);
    @(posedge clk);
    #1;
    check("idle_stop_busy_a", 32'(ifa.busy), 32'd0);
    drive(1'b0, 1'b0, 2'd0, '0, 1'b0);

    foreach (vecs[i]) run(i, vecs[i]);

    for (int i = 0; i < 6; i++) begin
      rv = mk($urandom_range(0, 3), $urandom_range(0, 255), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 3) == 0) ? -1 : $urandom_range(0, 1500), -1, -1,
              1'($urandom_range(0, 1)), -1, -1, -1, -1);
      if ($urandom_range(0, 3) == 0) rv.rst_edge = $urandom_range(2, 1500);
      if (rv.loop && rv.stop_edge < 0 && rv.rst_edge < 0) rv.rst_edge = $urandom_range(2, 1500);
      if (rv.stop_edge < 0 || rv.stop_edge > 700) begin
        rv.restart_edge = $urandom_range(1, 700);
        if (rv.rst_edge >= 0 && rv.restart_edge >= rv.rst_edge) rv.restart_edge = -1;
      end
      run(100 + i, rv);
    end

    repeat (2) @(posedge clk);
    #1;
    check("final_idle_a", 32'(ifa.busy), 32'd0);
    check("final_idle_b", 32'(ifb.busy), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pixel_stream_source.md
# pixel_stream_source

Raster pixel-stream transmitter that produces the valid-qualified pixel stream consumed by the line-alignment stage (`LineAlign`) and the 3x3 filter chain behind it. It generates one or more IMAGE_WIDTH x IMAGE_HEIGHT frames in row-major order with a selectable test pattern and optional horizontal blanking. It replaces hand-written stimulus loops and serves as the on-chip pattern source for filter bring-up.

## Interface
- DATA_WIDTH, 8, pixel width; legal range 1..16
- IMAGE_WIDTH, 128, pixels per line; must be >= 2
- IMAGE_HEIGHT, 6, lines per frame; must be >= 1
- HBLANK, 0, idle cycles (valid low) inserted after every line, including the last line of a frame
- CNT_WIDTH, 16, width of the internal column, row and blank counters
- clk  in  1  single clock; all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to begin a frame; honoured only in IDLE
- stop  in  1  one-cycle request to end streaming at the next line boundary
- loop  in  1  level; sampled at frame end; high means start the next frame automatically
- pattern  in  2  0 = column ramp, 1 = row ramp, 2 = LFSR, 3 = constant; sampled at start
- const_value  in  DATA_WIDTH  constant pixel value; sampled at start
- data_out  out  DATA_WIDTH  pixel value
- dataout_valid  out  1  data_out is a valid pixel this cycle
- line_start  out  1  high with the first pixel of each line
- line_end  out  1  high with the last pixel of each line
- frame_end  out  1  high with the last pixel of each frame
- busy  out  1  high whenever the FSM is outside IDLE

## Operation
- FSM states: IDLE, ACTIVE, BLANK.
  - IDLE -> ACTIVE on start. This latches pattern and const_value, clears col and row, and reseeds the LFSR.
  - ACTIVE emits one pixel per cycle. col increments per pixel.
  - At col = IMAGE_WIDTH-1, col wraps to 0 and row increments. The FSM then goes to BLANK if HBLANK > 0; otherwise the next line follows immediately.
  - BLANK counts HBLANK cycles with valid low, then returns to ACTIVE.
- End of frame (row = IMAGE_HEIGHT-1, last pixel):
  - If loop = 1 and no stop is pending: row clears and the next frame continues with the same pattern. The LFSR is not reseeded.
  - Otherwise: go to IDLE. If HBLANK > 0, first pass through BLANK, then go to IDLE.
- stop sets a pending flag. At the next line_end the FSM goes to IDLE, skipping the blanking, and the flag clears.
  - Lines are never truncated, so downstream line buffers stay aligned.
  - stop in IDLE is ignored.
- start while busy is ignored.
- start and stop in the same cycle in IDLE: the frame starts and stop is left pending.
- Patterns:
  - Pattern 0: data = (col+1) mod 2^DATA_WIDTH.
  - Pattern 1: data = (row+1) mod 2^DATA_WIDTH.
  - Pattern 2: 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1, seed 16'hACE1.
    - data = the low DATA_WIDTH bits of the LFSR.
    - The LFSR advances after each valid pixel.
  - Pattern 3: data = the latched const_value.
- data_out holds 0 whenever dataout_valid is low.

## Timing
- All outputs are registered.
- Reset: every output is 0, the FSM is IDLE, all counters are 0, and the LFSR holds 16'hACE1.
- rst asserted mid-frame takes effect on the next edge. The stream aborts with no line_end and no frame_end.
- Latency: start at edge N gives the first valid pixel (line_start = 1) in the cycle after edge N+1.
- The pixels of a line are on consecutive cycles. The gap between lines is exactly HBLANK cycles.
- With loop held high and HBLANK = 0, valid stays high continuously across frame boundaries.
- After a non-looping frame_end (or the line_end that honours stop): busy drops in the next cycle (HBLANK = 0), or after the blanking completes.
- Marker flags:
  - line_start, line_end and frame_end are single-cycle and are only high while dataout_valid is high.
  - With IMAGE_HEIGHT = 1, line_end and frame_end are high together.

## Configuration
- PIXEL_SRC_LFSR_EN
  - Defined: pattern 2 produces the LFSR sequence described above.
  - Undefined: the LFSR register and logic are not built, and pattern 2 behaves exactly as pattern 3 (constant).

## Test plan
- Default parameters, pattern 0, single start, loop = 0:
  - 768 valid cycles, all consecutive.
  - Values run 1..128 and repeat 6 times.
  - line_start is high 6 times; frame_end is high once, on pixel 768.
  - busy falls in the next cycle.
- HBLANK = 4, pattern 1:
  - Each line has 128 consecutive values equal to the row number (1..6).
  - There is a 4-cycle valid-low gap after every line; busy spans 6*132 cycles.
- Pattern 2 with PIXEL_SRC_LFSR_EN defined: first pixels are 0xE1 then 0x70. Without the macro, every pixel equals const_value.
- stop pulsed at pixel 200 of a loop = 1 stream: output ends at pixel 256 with line_end high, no frame_end, and busy low in the next cycle.
- rst pulsed at pixel 50 of a frame: all outputs are 0 in the next cycle. A new start then produces value 1 with line_start.
- start pulsed again mid-frame, then start and stop pulsed together from IDLE:
  - The mid-frame start has no effect on the running frame.
  - The combined pulse emits exactly one 128-pixel line, then returns to IDLE.
